// File: rtl/demux_2_32_buf.sv
// 1-to-2 demultiplexer with a per-channel FIFO and valid/ready handshakes on every side.
// Optional macro DEMUX_CNT_EN adds 16-bit completed-transfer counters cnt0/cnt1.
module demux_2_32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             o0_valid,
    input  logic             o0_ready,
    output logic [WIDTH-1:0] o0_data,
    output logic             o1_valid,
    input  logic             o1_ready,
    output logic [WIDTH-1:0] o1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

    logic [1:0]       full_w;
    logic [1:0]       valid_w;
    logic [1:0]       ready_w;
    logic [WIDTH-1:0] data_w [2];
`ifdef DEMUX_CNT_EN
    logic [15:0]      cnt_w [2];
`endif

    assign ready_w  = {o1_ready, o0_ready};
    // in_ready looks only at registered state, so consumer ready never reaches it.
    assign in_ready = ~full_w[in_sel];
    assign o0_valid = valid_w[0];
    assign o1_valid = valid_w[1];
    assign o0_data  = data_w[0];
    assign o1_data  = data_w[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [WIDTH-1:0] mem_d [DEPTH];
            logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
            logic [WIDTH-1:0] head_q, head_d;
            state_t           state_q, state_d;
            logic             push, pop;

            assign push = in_valid && in_ready && (in_sel == 1'(gi));
            assign pop  = valid_w[gi] && ready_w[gi];

            always_comb begin
                mem_d = mem_q;
                wp_d  = wp_q;
                rp_d  = rp_q;
                if (push) begin
                    mem_d[wp_q[AW-1:0]] = in_data;
                    wp_d = wp_q + PW'(1);
                end
                if (pop) begin
                    rp_d = rp_q + PW'(1);
                end
                if (wp_d == rp_d) begin
                    state_d = ST_EMPTY;
                end else if ((wp_d[AW] != rp_d[AW]) && (wp_d[AW-1:0] == rp_d[AW-1:0])) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_PARTIAL;
                end
                // Head register follows the next read slot; it keeps the last word once drained.
                head_d = (wp_d != rp_d) ? mem_d[rp_d[AW-1:0]] : head_q;
            end

            // Storage lives in flops so an asynchronous reset can clear it completely.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wp_q    <= '0;
                    rp_q    <= '0;
                    head_q  <= '0;
                    state_q <= ST_EMPTY;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else begin
                    wp_q    <= wp_d;
                    rp_q    <= rp_d;
                    head_q  <= head_d;
                    state_q <= state_d;
                    mem_q   <= mem_d;
                end
            end

            assign valid_w[gi] = (state_q != ST_EMPTY);
            assign full_w[gi]  = (state_q == ST_FULL);
            assign data_w[gi]  = head_q;

`ifdef DEMUX_CNT_EN
            logic [15:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q + 16'(pop);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_w[gi] = cnt_q;
`endif
        end
    endgenerate

`ifdef DEMUX_CNT_EN
    assign cnt0 = cnt_w[0];
    assign cnt1 = cnt_w[1];
`endif

endmodule

// File: tb/tb_demux_2_32_buf.sv
// Scoreboard bench for demux_2_32_buf: per-channel expected queues model the FIFOs as plain
// lists; a monitor compares handshakes, head data, valids and in_ready once per cycle.
module tb_demux_2_32_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sel = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             o0_valid, o1_valid;
    logic             o0_ready = 1'b0, o1_ready = 1'b0;
    logic [WIDTH-1:0] o0_data, o1_data;
`ifdef DEMUX_CNT_EN
    logic [15:0]      cnt0, cnt1;
`endif

    demux_2_32_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o0_data  (o0_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .o1_data  (o1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Reference model: each channel is simply a list of words not yet delivered.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] last0 = '0, last1 = '0;
    logic [15:0]      pops0 = '0, pops1 = '0;
    int               accepted = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        pops0 = '0;
        pops1 = '0;
    endtask

    // Monitor: samples 1 time unit before the rising edge.
    always @(negedge clk) begin
        #4;
        if (mon_en) begin
            logic [WIDTH-1:0] e0, e1;
            int occ;
            e0  = (q0.size() > 0) ? q0[0] : last0;
            e1  = (q1.size() > 0) ? q1[0] : last1;
            occ = in_sel ? q1.size() : q0.size();
            check(o0_valid == (q0.size() > 0), "o0_valid", 32'(o0_valid), 32'(q0.size() > 0));
            check(o1_valid == (q1.size() > 0), "o1_valid", 32'(o1_valid), 32'(q1.size() > 0));
            check(o0_data == e0, "o0_data", o0_data, e0);
            check(o1_data == e1, "o1_data", o1_data, e1);
            check(in_ready == (occ < DEPTH), "in_ready", 32'(in_ready), 32'(occ < DEPTH));
`ifdef DEMUX_CNT_EN
            check(cnt0 == pops0, "cnt0", 32'(cnt0), 32'(pops0));
            check(cnt1 == pops1, "cnt1", 32'(cnt1), 32'(pops1));
`endif
            if (o0_ready && q0.size() > 0) begin
                last0 = q0.pop_front();
                pops0 = pops0 + 16'd1;
                $display("pop  ch0 %h", last0);
            end
            if (o1_ready && q1.size() > 0) begin
                last1 = q1.pop_front();
                pops1 = pops1 + 16'd1;
                $display("pop  ch1 %h", last1);
            end
            if (in_valid && in_ready) begin
                accepted++;
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
                $display("push ch%0d %h", in_sel, in_data);
            end
        end
    end

    task automatic cyc(input bit v, input bit sel, input logic [WIDTH-1:0] d,
                       input bit r0, input bit r1);
        @(negedge clk);
        in_valid = v;
        in_sel   = sel;
        in_data  = d;
        o0_ready = r0;
        o1_ready = r1;
    endtask

    task automatic check_idle(input string tag);
        check(o0_valid == 1'b0, {tag, "_o0_valid"}, 32'(o0_valid), 32'd0);
        check(o1_valid == 1'b0, {tag, "_o1_valid"}, 32'(o1_valid), 32'd0);
        check(in_ready == 1'b1, {tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef DEMUX_CNT_EN
        check(cnt0 == 16'd0, {tag, "_cnt0"}, 32'(cnt0), 32'd0);
        check(cnt1 == 16'd0, {tag, "_cnt1"}, 32'(cnt1), 32'd0);
`endif
    endtask

    initial begin
        // 1. Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            #4;
            check_idle("reset");
            check(o0_data == '0 && o1_data == '0, "reset_data", o0_data | o1_data, 32'd0);
        end
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        #2 rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // 2. Routing
        cyc(1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 32'h5A5A_0002, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // 3. Backpressure on channel 0, channel 1 still flows
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'hC000_0000 + i, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 32'hD000_0001, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // 4. Full channel 0 with simultaneous pop and refused push
        cyc(1'b1, 1'b0, 32'hE000_0001, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'hE000_0002, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'hE000_0003, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 32'hE000_0003, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'hE000_0004, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // 5. Pointer wrap on channel 1 with toggling consumer
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, $urandom, 1'b1, 1'(i & 1));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));

        // 6. Mid-operation asynchronous reset with both FIFOs full
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'(i & 1), 32'hF000_0000 + i, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        mon_en   = 1'b0;
        check(o0_valid && o1_valid, "prefill_both_valid", 32'({o1_valid, o0_valid}), 32'd3);
        #1 rst_n = 1'b0;
        #1 check_idle("async_reset");
        model_reset();
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

        @(negedge clk);
        #4;
        check(q0.size() == 0 && q1.size() == 0, "drained",
              32'(q0.size() + q1.size()), 32'd0);
        check(accepted > 20, "accepted_count", 32'(accepted), 32'd21);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
